// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage controller and a variable-latency
// data memory.
//
// Signals:
//   mem_req    - request, held high from launch until the completion pulse
//   mem_we     - 1 = write, 0 = read
//   mem_addr   - word address (byte offset already stripped)
//   mem_wdata  - store data
//   mem_ready  - one-cycle completion pulse from memory
//   mem_rdata  - read data, valid while mem_ready = 1
//
// Modports:
//   master - MEM stage side (drives the request fields)
//   slave  - memory side (drives ready and read data)
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller.
//
// Sits behind the EX/MEM register, runs one data-memory access per load or
// store over a req/ready handshake, stalls the front of the pipe while the
// access is outstanding, and holds the MEM/WB pipeline register.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   *_in            - EX/MEM register outputs (enables, PC, ALU value,
//                     store data, destination register)
//   mem             - data-memory bus (master side)
//   freeze          - stall for IF/ID/EX and the EX/MEM register
//   WB_EN, MEM_R_EN, PC, ALU_result, MEM_read_value, Dest
//                   - MEM/WB register outputs feeding write-back
module mem_stage_ctrl #(
    parameter logic [31:0] MEM_BASE = 32'd1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    WB_EN_in,
    input  logic                    MEM_R_EN_in,
    input  logic                    MEM_W_EN_in,
    input  logic [31:0]             PC_in,
    input  logic [31:0]             ALU_result_in,
    input  logic [31:0]             ST_val_in,
    input  logic [4:0]              Dest_in,

    mem_stage_ctrl_if.master        mem,

    output logic                    freeze,

    output logic                    WB_EN,
    output logic                    MEM_R_EN,
    output logic [31:0]             PC,
    output logic [31:0]             ALU_result,
    output logic [31:0]             MEM_read_value,
    output logic [4:0]              Dest
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        acc;
    logic        launch;
    logic        finish;
    logic [29:0] word_addr;
    logic [1:0]  byte_off_unused;
    logic [31:0] rdata_cap;

    assign acc = MEM_R_EN_in | MEM_W_EN_in;

    // Rebase to the start of data memory, then drop the byte offset.
    assign {word_addr, byte_off_unused} = ALU_result_in - MEM_BASE;

    assign launch = (state == IDLE) && acc;
    assign finish = (state == WAIT) && mem.mem_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE releases freeze for one cycle so the EX/MEM register can advance;
    // it never launches, because the inputs still show the finished access.
    always_comb begin
        state_next = state;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                freeze = acc;
                if (acc) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                freeze = 1'b1;
                if (mem.mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // freeze is combinational from the inputs; keep it low while in reset.
        if (!rst) begin
            freeze = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Memory request and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            rdata_cap     <= '0;
        end else begin
            if (launch) begin
                mem.mem_req   <= 1'b1;
                // A load wins when both enables are set.
                mem.mem_we    <= MEM_W_EN_in & ~MEM_R_EN_in;
                mem.mem_addr  <= word_addr;
                mem.mem_wdata <= ST_val_in;
            end else if (finish) begin
                mem.mem_req <= 1'b0;
                if (!mem.mem_we) begin
                    rdata_cap <= mem.mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    // While frozen, a bubble is inserted by clearing only the enables; the
    // data fields keep their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            PC             <= '0;
            ALU_result     <= '0;
            MEM_read_value <= '0;
            Dest           <= '0;
        end else if (freeze) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
        end else begin
            WB_EN          <= WB_EN_in;
            MEM_R_EN       <= MEM_R_EN_in;
            PC             <= PC_in;
            ALU_result     <= ALU_result_in;
            Dest           <= Dest_in;
            MEM_read_value <= (state == DONE) ? rdata_cap : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl. The bench plays both the EX/MEM
// register (holding an instruction until freeze is low) and the data memory
// (answering each request after a chosen latency). Expectations come from an
// instruction-level model: MEM/WB contents, request fields and freeze length
// per instruction.
module tb_mem_stage_ctrl;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] PC_in, ALU_result_in, ST_val_in;
    logic [4:0]  Dest_in;
    logic        freeze, WB_EN, MEM_R_EN;
    logic [31:0] PC, ALU_result, MEM_read_value;
    logic [4:0]  Dest;

    mem_stage_ctrl_if mem_bus();

    mem_stage_ctrl #(.MEM_BASE(BASE)) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_EN_in       (WB_EN_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .PC_in          (PC_in),
        .ALU_result_in  (ALU_result_in),
        .ST_val_in      (ST_val_in),
        .Dest_in        (Dest_in),
        .mem            (mem_bus.master),
        .freeze         (freeze),
        .WB_EN          (WB_EN),
        .MEM_R_EN       (MEM_R_EN),
        .PC             (PC),
        .ALU_result     (ALU_result),
        .MEM_read_value (MEM_read_value),
        .Dest           (Dest)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model of the MEM/WB data fields and of the last loaded word.
    logic [31:0] m_pc, m_alu, m_rv, m_last_load;
    logic [4:0]  m_dest;

    typedef struct {
        logic        wb, mr, mw;
        logic [31:0] pc, alu, st;
        logic [4:0]  dest;
        int unsigned lat;
        logic [31:0] rdata;
        bit          spur;
        logic [29:0] exp_addr;
        logic        exp_we;
        int unsigned exp_frz;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_alu = '0; m_rv = '0; m_last_load = '0; m_dest = '0;
    endtask

    // Present one instruction at EX/MEM, serve its memory access if any,
    // and check everything up to and including its arrival at MEM/WB.
    // Called at posedge+1.
    task automatic run_instr(input logic wb, input logic mr, input logic mw,
                             input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] st, input logic [4:0] dest,
                             input int unsigned lat, input logic [31:0] rdata,
                             input bit spur, input logic [29:0] exp_addr,
                             input logic exp_we, input int unsigned exp_frz);
        int unsigned frz_cnt;
        WB_EN_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = mw;
        PC_in = pc; ALU_result_in = alu; ST_val_in = st; Dest_in = dest;
        mem_bus.mem_ready = spur;
        mem_bus.mem_rdata = $urandom;
        #1;
        if (mr | mw) begin
            frz_cnt = 0;
            check("req_low_before_launch", mem_bus.mem_req, 1'b0);
            check("freeze_on_request", freeze, 1'b1);
            if (freeze) frz_cnt++;
            @(posedge clk); #1;
            mem_bus.mem_ready = 1'b0;
            for (int unsigned k = 1; k <= lat; k++) begin
                check("req_high_wait", mem_bus.mem_req, 1'b1);
                check("mem_we", mem_bus.mem_we, exp_we);
                check("mem_addr", mem_bus.mem_addr, exp_addr);
                check("mem_wdata", mem_bus.mem_wdata, st);
                check("bubble_wb_en", WB_EN, 1'b0);
                check("bubble_mem_r_en", MEM_R_EN, 1'b0);
                check("hold_pc", PC, m_pc);
                check("hold_alu", ALU_result, m_alu);
                check("hold_rv", MEM_read_value, m_rv);
                if (freeze) frz_cnt++;
                if (k == lat) begin
                    mem_bus.mem_ready = 1'b1;
                    mem_bus.mem_rdata = rdata;
                end else begin
                    mem_bus.mem_rdata = $urandom;
                end
                @(posedge clk); #1;
                mem_bus.mem_ready = 1'b0;
            end
            check("req_low_done", mem_bus.mem_req, 1'b0);
            if (freeze) frz_cnt++;
            check("freeze_cycles", frz_cnt, exp_frz);
            mem_bus.mem_ready = spur;
            mem_bus.mem_rdata = $urandom;
            if (mr) m_last_load = rdata;
            m_rv = m_last_load;
            @(posedge clk); #1;
            mem_bus.mem_ready = 1'b0;
            check("req_low_after", mem_bus.mem_req, 1'b0);
        end else begin
            check("freeze_alu", freeze, 1'b0);
            check("req_alu", mem_bus.mem_req, 1'b0);
            m_rv = '0;
            @(posedge clk); #1;
            mem_bus.mem_ready = 1'b0;
        end
        m_pc = pc; m_alu = alu; m_dest = dest;
        check("wb_en", WB_EN, wb);
        check("mem_r_en", MEM_R_EN, mr);
        check("pc", PC, m_pc);
        check("alu_result", ALU_result, m_alu);
        check("dest", Dest, m_dest);
        check("mem_read_value", MEM_read_value, m_rv);
    endtask

    logic        r_wb, r_mr, r_mw;
    logic [31:0] r_alu;
    int unsigned r_kind, r_lat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // {wb, mr, mw, pc, alu, st, dest, lat, rdata, spur, addr, we, freeze cycles}
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h7,        32'h0,        5'd5,  0, 32'h0,         1'b0, 30'd0,   1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'd1028,     32'h0,        5'd3,  3, 32'hDEADBEEF,  1'b0, 30'd1,   1'b0, 4};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h108, 32'd1032,     32'h1234,     5'd0,  1, 32'h0,         1'b0, 30'd2,   1'b1, 2};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'd2000,     32'h0,        5'd7,  2, 32'hCAFEF00D,  1'b0, 30'd244, 1'b0, 3};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h110, 32'd1100,     32'hA5A5A5A5, 5'd0,  4, 32'h0,         1'b0, 30'd19,  1'b1, 5};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h114, 32'd1024,     32'hFFFF,     5'd9,  2, 32'h000055AA,  1'b1, 30'd0,   1'b0, 3};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h118, 32'hFFFFFFFF, 32'h0,        5'd31, 0, 32'h0,         1'b1, 30'd0,   1'b0, 0};

        rst = 1'b0;
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        PC_in = '0; ALU_result_in = '0; ST_val_in = '0; Dest_in = '0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
        model_reset();
        #1;
        check("rst_req", mem_bus.mem_req, 1'b0);
        check("rst_we", mem_bus.mem_we, 1'b0);
        check("rst_addr", mem_bus.mem_addr, 30'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_freeze", freeze, 1'b0);
        check("rst_wb_en", WB_EN, 1'b0);
        check("rst_pc", PC, 32'd0);
        check("rst_rv", MEM_read_value, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].wb, tbl[i].mr, tbl[i].mw, tbl[i].pc, tbl[i].alu,
                      tbl[i].st, tbl[i].dest, tbl[i].lat, tbl[i].rdata,
                      tbl[i].spur, tbl[i].exp_addr, tbl[i].exp_we, tbl[i].exp_frz);
        end

        // Reset while an access is waiting for memory.
        WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b0;
        PC_in = 32'h200; ALU_result_in = 32'd1040; ST_val_in = '0; Dest_in = 5'd12;
        @(posedge clk); #1;
        check("pre_rst_req", mem_bus.mem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_req", mem_bus.mem_req, 1'b0);
        check("midrst_freeze", freeze, 1'b0);
        check("midrst_wb_en", WB_EN, 1'b0);
        check("midrst_mem_r_en", MEM_R_EN, 1'b0);
        check("midrst_pc", PC, 32'd0);
        check("midrst_alu", ALU_result, 32'd0);
        check("midrst_rv", MEM_read_value, 32'd0);
        check("midrst_dest", Dest, 5'd0);
        model_reset();
        @(posedge clk); #1;
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_instr(1'b1, 1'b0, 1'b0, 32'h204, 32'h55, 32'h0, 5'd4, 0, 32'h0, 1'b0, 30'd0, 1'b0, 0);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            r_kind = $urandom_range(0, 3);
            r_mr   = (r_kind == 1) || (r_kind == 3);
            r_mw   = (r_kind == 2) || (r_kind == 3);
            r_wb   = 1'($urandom_range(0, 1));
            r_alu  = ($urandom_range(0, 1) != 0) ? $urandom : BASE + $urandom_range(0, 4095);
            r_lat  = $urandom_range(1, 5);
            run_instr(r_wb, r_mr, r_mw, $urandom, r_alu, $urandom, 5'($urandom_range(0, 31)),
                      r_lat, $urandom, 1'($urandom_range(0, 1)),
                      30'((r_alu - BASE) >> 2), r_mw & ~r_mr, r_lat + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
